// File: rtl/axis_packet_width_converter.sv
// axis_packet_width_converter: AXI-Stream width converter carrying tkeep/tlast/tuser/tdest
module axis_packet_width_converter #(
  parameter int SLAVE_WIDTH  = 2,
  parameter int MASTER_WIDTH = 4,
  parameter int USER_WIDTH   = 1,
  parameter int DEST_WIDTH   = 1
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic [SLAVE_WIDTH*8-1:0]  s_axis_tdata,
  input  logic [SLAVE_WIDTH-1:0]    s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  input  logic [DEST_WIDTH-1:0]     s_axis_tdest,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [MASTER_WIDTH*8-1:0] m_axis_tdata,
  output logic [MASTER_WIDTH-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  output logic [DEST_WIDTH-1:0]     m_axis_tdest,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);
  localparam int RATIO = MASTER_WIDTH >= SLAVE_WIDTH ? MASTER_WIDTH / SLAVE_WIDTH
                                                     : SLAVE_WIDTH / MASTER_WIDTH;
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
  if ((MASTER_WIDTH >= SLAVE_WIDTH ? MASTER_WIDTH % SLAVE_WIDTH
                                   : SLAVE_WIDTH % MASTER_WIDTH) != 0) begin : g_bad
    $error("axis_packet_width_converter: widths must be integer multiples");
  end
  if (MASTER_WIDTH >= SLAVE_WIDTH) begin : g_up
    // Equal width is the RATIO=1 case: every beat completes its group.
    logic [IW-1:0]             idx;
    logic [MASTER_WIDTH*8-1:0] st_data, nx_data;
    logic [MASTER_WIDTH-1:0]   st_keep, nx_keep;
    logic                      acc, done;
    always_comb begin
      s_axis_tready = !arst && (!m_axis_tvalid || m_axis_tready);
      acc = s_axis_tvalid && s_axis_tready;
      done = idx == IW'(RATIO - 1) || s_axis_tlast;
      nx_data = st_data | ((MASTER_WIDTH*8)'(s_axis_tdata) << (idx * SLAVE_WIDTH * 8));
      nx_keep = st_keep | (MASTER_WIDTH'(s_axis_tkeep) << (idx * SLAVE_WIDTH));
    end
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        idx <= '0;
        st_data <= '0;
        st_keep <= '0;
        m_axis_tdata <= '0;
        m_axis_tkeep <= '0;
        m_axis_tlast <= 1'b0;
        m_axis_tuser <= '0;
        m_axis_tdest <= '0;
        m_axis_tvalid <= 1'b0;
      end else begin
        if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
        if (acc && done) begin
          m_axis_tdata <= nx_data;
          m_axis_tkeep <= nx_keep;
          m_axis_tlast <= s_axis_tlast;
          m_axis_tuser <= s_axis_tuser;
          m_axis_tdest <= s_axis_tdest;
          m_axis_tvalid <= 1'b1;
          st_data <= '0;
          st_keep <= '0;
          idx <= '0;
        end else if (acc) begin
          st_data <= nx_data;
          st_keep <= nx_keep;
          idx <= idx + 1'b1;
        end
      end
    end
  end else begin : g_dn
    logic [SLAVE_WIDTH*8-1:0] h_data;
    logic [SLAVE_WIDTH-1:0]   h_keep;
    logic                     h_last, held, above, acc, in_any;
    logic [USER_WIDTH-1:0]    h_user;
    logic [DEST_WIDTH-1:0]    h_dest;
    logic [IW-1:0]            seg, nxt, first;
    // Downward scan so the lowest qualifying segment wins.
    always_comb begin
      above = 1'b0;
      nxt = seg;
      first = '0;
      for (int i = RATIO - 1; i >= 0; i--) begin
        if (i > int'(seg) && |h_keep[i*MASTER_WIDTH +: MASTER_WIDTH]) begin
          above = 1'b1;
          nxt = IW'(i);
        end
        if (|s_axis_tkeep[i*MASTER_WIDTH +: MASTER_WIDTH]) first = IW'(i);
      end
      in_any = |s_axis_tkeep;
      m_axis_tvalid = held;
      m_axis_tdata = h_data[seg*MASTER_WIDTH*8 +: MASTER_WIDTH*8];
      m_axis_tkeep = h_keep[seg*MASTER_WIDTH +: MASTER_WIDTH];
      m_axis_tlast = h_last && !above;
      m_axis_tuser = h_user;
      m_axis_tdest = h_dest;
      s_axis_tready = !arst && (!held || (m_axis_tready && !above));
      acc = s_axis_tvalid && s_axis_tready;
    end
    always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
        held <= 1'b0;
        seg <= '0;
        h_data <= '0;
        h_keep <= '0;
        h_last <= 1'b0;
        h_user <= '0;
        h_dest <= '0;
      end else begin
        if (held && m_axis_tready) begin
          if (above) seg <= nxt;
          else held <= 1'b0;
        end
        // An empty non-final beat is accepted but never held.
        if (acc && (in_any || s_axis_tlast)) begin
          held <= 1'b1;
          seg <= first;
          h_data <= s_axis_tdata;
          h_keep <= s_axis_tkeep;
          h_last <= s_axis_tlast;
          h_user <= s_axis_tuser;
          h_dest <= s_axis_tdest;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_packet_width_converter.sv
// tb_axis_packet_width_converter: upsize 2->4, downsize 4->2 and 2->2 against a packet-level model
module tb_axis_packet_width_converter;
  typedef struct {logic [31:0] d; logic [3:0] k; logic l, u, t;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, miscompares = 0, rmode = 0;
  ent_t q[3][$];
  logic pend[3] = '{default: 1'b0};
  logic [39:0] prev[3];
  logic [31:0] ud = '0;
  logic [3:0] uk = '0;
  int uc = 0;
  logic [15:0] u_sd = '0, u_md, e_sd = '0, e_md, d_md;
  logic [31:0] d_sd = '0, u_md32;
  logic [1:0] u_sk = '0, e_sk = '0, e_mk, d_mk;
  logic [3:0] d_sk = '0, u_mk;
  logic u_sl = 0, u_su = 0, u_st = 0, u_sv = 0, u_sr, u_ml, u_mu, u_mt, u_mv, u_mr;
  logic d_sl = 0, d_su = 0, d_st = 0, d_sv = 0, d_sr, d_ml, d_mu, d_mt, d_mv, d_mr;
  logic e_sl = 0, e_su = 0, e_st = 0, e_sv = 0, e_sr, e_ml, e_mu, e_mt, e_mv, e_mr;

  axis_packet_width_converter #(.SLAVE_WIDTH(2), .MASTER_WIDTH(4), .USER_WIDTH(1), .DEST_WIDTH(1)) u_up (
    .aclk(clk), .arst(rst), .s_axis_tdata(u_sd), .s_axis_tkeep(u_sk), .s_axis_tlast(u_sl),
    .s_axis_tuser(u_su), .s_axis_tdest(u_st), .s_axis_tvalid(u_sv), .s_axis_tready(u_sr),
    .m_axis_tdata(u_md32), .m_axis_tkeep(u_mk), .m_axis_tlast(u_ml), .m_axis_tuser(u_mu),
    .m_axis_tdest(u_mt), .m_axis_tvalid(u_mv), .m_axis_tready(u_mr));
  axis_packet_width_converter #(.SLAVE_WIDTH(4), .MASTER_WIDTH(2), .USER_WIDTH(1), .DEST_WIDTH(1)) u_dn (
    .aclk(clk), .arst(rst), .s_axis_tdata(d_sd), .s_axis_tkeep(d_sk), .s_axis_tlast(d_sl),
    .s_axis_tuser(d_su), .s_axis_tdest(d_st), .s_axis_tvalid(d_sv), .s_axis_tready(d_sr),
    .m_axis_tdata(d_md), .m_axis_tkeep(d_mk), .m_axis_tlast(d_ml), .m_axis_tuser(d_mu),
    .m_axis_tdest(d_mt), .m_axis_tvalid(d_mv), .m_axis_tready(d_mr));
  axis_packet_width_converter #(.SLAVE_WIDTH(2), .MASTER_WIDTH(2), .USER_WIDTH(1), .DEST_WIDTH(1)) u_eq (
    .aclk(clk), .arst(rst), .s_axis_tdata(e_sd), .s_axis_tkeep(e_sk), .s_axis_tlast(e_sl),
    .s_axis_tuser(e_su), .s_axis_tdest(e_st), .s_axis_tvalid(e_sv), .s_axis_tready(e_sr),
    .m_axis_tdata(e_md), .m_axis_tkeep(e_mk), .m_axis_tlast(e_ml), .m_axis_tuser(e_mu),
    .m_axis_tdest(e_mt), .m_axis_tvalid(e_mv), .m_axis_tready(e_mr));

  assign u_md = u_md32[15:0];
  initial forever #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output ports of one DUT: scoreboard pop on handshake, stability and tready under stall.
  task automatic mon(int w, string nm, logic [31:0] md, logic [3:0] mk, logic ml, logic mu,
                     logic mt, logic mv, logic mr, logic sr);
    ent_t e;
    logic [39:0] snap;
    snap = {mv, ml, mu, mt, mk, md};
    if (rst) pend[w] = 1'b0;
    else begin
      if (pend[w]) chk({nm, "_hold"}, snap, prev[w]);
      if (mv && !mr) chk({nm, "_srdy_stall"}, sr, 0);
      if (mv && mr) begin
        if (q[w].size() == 0) chk({nm, "_extra_beat"}, 1, 0);
        else begin
          e = q[w].pop_front();
          chk({nm, "_data"}, md, e.d);
          chk({nm, "_keep"}, mk, e.k);
          chk({nm, "_last"}, ml, e.l);
          chk({nm, "_user"}, mu, e.u);
          chk({nm, "_dest"}, mt, e.t);
        end
      end
      pend[w] = mv && !mr;
      prev[w] = snap;
    end
  endtask

  always @(negedge clk) mon(0, "up", u_md32, u_mk, u_ml, u_mu, u_mt, u_mv, u_mr, u_sr);
  always @(negedge clk) mon(1, "dn", {16'h0, d_md}, {2'b0, d_mk}, d_ml, d_mu, d_mt, d_mv, d_mr, d_sr);
  always @(negedge clk) mon(2, "eq", {16'h0, e_md}, {2'b0, e_mk}, e_ml, e_mu, e_mt, e_mv, e_mr, e_sr);

  // rmode 0: always ready, 1: random ready, 2: upsizer stalled
  initial forever begin
    u_mr = rmode == 1 ? $urandom_range(0, 3) != 0 : rmode != 2;
    d_mr = rmode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
    e_mr = rmode == 1 ? $urandom_range(0, 3) != 0 : 1'b1;
    @(posedge clk);
    #1;
  end

  // Packet-level reference: byte groups for upsize, non-empty halves for downsize.
  task automatic model(int w, logic [31:0] d, logic [3:0] k, logic l, logic u, logic t);
    int li;
    if (w == 0) begin
      ud = ud | (32'(d[15:0]) << (uc * 16));
      uk = uk | (4'(k[1:0]) << (uc * 2));
      uc++;
      if (uc == 2 || l) begin
        q[0].push_back('{ud, uk, l, u, t});
        ud = '0;
        uk = '0;
        uc = 0;
      end
    end else if (w == 1) begin
      li = -1;
      for (int i = 0; i < 2; i++) if (k[2*i +: 2] != 0) li = i;
      if (li < 0 && l) q[1].push_back('{32'(d[15:0]), 4'h0, 1'b1, u, t});
      for (int i = 0; i < 2; i++)
        if (k[2*i +: 2] != 0) q[1].push_back('{32'(d[16*i +: 16]), 4'(k[2*i +: 2]), l && i == li, u, t});
    end else q[2].push_back('{32'(d[15:0]), 4'(k[1:0]), l, u, t});
  endtask

  function automatic logic srdy(int w);
    return w == 0 ? u_sr : w == 1 ? d_sr : e_sr;
  endfunction

  task automatic send(int w, logic [31:0] d, logic [3:0] k, logic l, logic u, logic t);
    int n;
    n = 0;
    if (w == 0) {u_sd, u_sk, u_sl, u_su, u_st, u_sv} = {d[15:0], k[1:0], l, u, t, 1'b1};
    else if (w == 1) {d_sd, d_sk, d_sl, d_su, d_st, d_sv} = {d, k, l, u, t, 1'b1};
    else {e_sd, e_sk, e_sl, e_su, e_st, e_sv} = {d[15:0], k[1:0], l, u, t, 1'b1};
    @(negedge clk);
    while (!srdy(w) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!srdy(w)) chk("send_stall", srdy(w), 1);
    else model(w, d, k, l, u, t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int w);
    if (w == 0) u_sv = 1'b0;
    else if (w == 1) d_sv = 1'b0;
    else e_sv = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pu, pt;
    logic [3:0] k;
    int len, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_up_valid", u_mv, 0);
    chk("rst_up_srdy", u_sr, 0);
    chk("rst_dn_valid", d_mv, 0);
    chk("rst_eq_srdy", e_sr, 0);
    rst = 1'b0;
    tick();
    // Upsize full group and latency
    send(0, 'h1100, 4'h3, 0, 0, 0);
    chk("t1_no_early", u_mv, 0);
    send(0, 'h3322, 4'h3, 1, 0, 0);
    idle(0);
    chk("t1_valid", u_mv, 1);
    chk("t1_data", u_md32, 32'h33221100);
    chk("t1_keep", u_mk, 4'hF);
    chk("t1_last", u_ml, 1);
    tick();
    chk("t1_drained", u_mv, 0);
    // Upsize early tlast, then a full group must start at slot 0
    send(0, 'h1100, 4'h3, 1, 0, 1);
    idle(0);
    chk("t2_data", u_md32, 32'h00001100);
    chk("t2_keep", u_mk, 4'h3);
    chk("t2_dest", u_mt, 1);
    send(0, 'hBBAA, 4'h3, 0, 0, 0);
    send(0, 'hDDCC, 4'h3, 1, 0, 0);
    idle(0);
    chk("t2_realign", u_md32, 32'hDDCCBBAA);
    // Downsize two segments
    send(1, 'hDDCCBBAA, 4'hF, 1, 0, 0);
    idle(1);
    chk("t3_seg0", d_md, 16'hBBAA);
    chk("t3_last0", d_ml, 0);
    chk("t3_srdy_mid", d_sr, 0);
    tick();
    chk("t3_seg1", d_md, 16'hDDCC);
    chk("t3_last1", d_ml, 1);
    tick();
    chk("t3_done", d_mv, 0);
    // Segment skip, empty non-last drop, empty last
    send(1, 'hDDCCBBAA, 4'hC, 1, 0, 0);
    idle(1);
    chk("t4_data", d_md, 16'hDDCC);
    chk("t4_keep", d_mk, 2'h3);
    chk("t4_last", d_ml, 1);
    tick();
    send(1, 'h12345678, 4'h0, 0, 0, 0);
    idle(1);
    chk("t4_drop", d_mv, 0);
    send(1, 'h12345678, 4'h0, 1, 1, 0);
    idle(1);
    chk("t4_empty_keep", d_mk, 0);
    chk("t4_empty_last", d_ml, 1);
    tick();
    // Backpressure on a completed group
    rmode = 2;
    @(posedge clk);
    #2;
    send(0, 'h5A5A, 4'h3, 0, 1, 1);
    send(0, 'hA5A5, 4'h3, 1, 1, 1);
    idle(0);
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("t5_valid", u_mv, 1);
      chk("t5_srdy", u_sr, 0);
      chk("t5_data", u_md32, 32'hA5A55A5A);
    end
    rmode = 0;
    for (int i = 0; i < 8; i++) send(0, $urandom, 4'h3, i == 3 || i == 7, 0, 1);
    idle(0);
    repeat (10) tick();
    // Reset mid-group
    send(0, 'h1100, 4'h3, 0, 0, 0);
    idle(0);
    rst = 1'b1;
    #1;
    chk("t6_rst_data", u_md32, 0);
    chk("t6_rst_keep", u_mk, 0);
    chk("t6_rst_last", u_ml, 0);
    chk("t6_rst_srdy", u_sr, 0);
    ud = '0;
    uk = '0;
    uc = 0;
    tick();
    rst = 1'b0;
    tick();
    send(0, 'h5544, 4'h3, 0, 0, 0);
    send(0, 'h7766, 4'h3, 1, 0, 0);
    idle(0);
    chk("t6_data", u_md32, 32'h77665544);
    tick();
    // Randomized packets with random backpressure
    rmode = 1;
    for (int w = 0; w < 3; w++) begin
      for (int p = 0; p < 50; p++) begin
        len = $urandom_range(1, 6);
        pu = 1'($urandom);
        pt = 1'($urandom);
        for (int b = 0; b < len; b++) begin
          k = $urandom_range(0, 7) == 0 ? 4'h0 : 4'($urandom);
          send(w, $urandom, k, b == len - 1, pu, pt);
          if ($urandom_range(0, 3) == 0) begin
            idle(w);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end
      idle(w);
    end
    rmode = 0;
    n = 0;
    while (q[0].size() + q[1].size() + q[2].size() != 0 && n < 500) begin
      n++;
      tick();
    end
    chk("drain", q[0].size() + q[1].size() + q[2].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
